// File: rtl/tbuf_pkg.sv
// Shared constants and FSM encodings for the transpose-buffer sequencer.
package tbuf_pkg;

    localparam int TBUF_DW   = 64;
    localparam int TBUF_AW   = 3;
    localparam int TBUF_NROW = 8;
    localparam int TBUF_SKID = 2;

    typedef enum logic {
        W_FILL = 1'b0,
        W_FULL = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rstate_t;

endpackage

// File: rtl/tbuf_if.sv
// dualram-facing bus of the transpose buffer; master is the sequencer.
interface tbuf_if #(
    parameter int DW = 64,
    parameter int AW = 3
);
    logic          rnw;
    logic [AW-1:0] wa;
    logic [7:0]    be;
    logic [DW-1:0] di;
    logic          din_valid;
    logic [AW-1:0] ra;
    logic [DW-1:0] do_in;

    modport master (
        output rnw, wa, be, di, din_valid, ra,
        input  do_in
    );

    modport slave (
        input  rnw, wa, be, di, din_valid, ra,
        output do_in
    );
endinterface

// File: rtl/tbuf_skid_fifo.sv
// Fall-through skid FIFO: an incoming word is visible at the head in the
// same cycle when the FIFO is empty, and is only stored if not taken.
module skid_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          empty, pop, store, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (cnt == '0);
    assign out_valid = !empty || in_valid;
    assign out_data  = !empty ? mem[rd_ptr] : (in_valid ? in_data : '0);
    assign pop       = out_valid && out_ready;
    assign store     = in_valid && !(empty && out_ready);
    assign deq       = pop && !empty;
    assign occ       = cnt;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({store, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/tbuf_ctrl.sv
// Ping-pong transpose buffer sequencer: fills one dualram bank with rows while
// the other bank is read out as columns through a skid FIFO.
//
//   state   | meaning
//   W_FILL  | accepting rows into the write bank
//   W_FULL  | write bank complete, waiting for the reader to go idle
//   R_IDLE  | no bank to read
//   R_BURST | issuing ra 0..NROW-1 against the read bank
module tbuf_ctrl
    import tbuf_pkg::*;
#(
    parameter int DW   = TBUF_DW,
    parameter int AW   = TBUF_AW,
    parameter int NROW = TBUF_NROW,
    parameter int SKID = TBUF_SKID
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          row_valid,
    input  logic [DW-1:0] row_data,
    output logic          row_ready,
    tbuf_if.master        ram,
    output logic          col_valid,
    output logic [DW-1:0] col_data,
    output logic [AW-1:0] col_idx,
    output logic          col_last,
    input  logic          col_ready
);
    localparam int OW = $clog2(SKID + 1);

    wstate_t       w_state, w_next;
    rstate_t       r_state, r_next;
    logic [AW-1:0] wcnt, rcnt, infl_idx;
    logic          rnw_q, inflight;
    logic          row_acc, swap, issue, pop;
    logic [OW-1:0] occ;
    logic [OW:0]   level;
    logic [DW+AW:0] push_word, head;

    assign row_ready = rst_n && (w_state == W_FILL);
    assign row_acc   = row_valid && row_ready;
    assign swap      = (w_state == W_FULL) && (r_state == R_IDLE);
    assign pop       = col_valid && col_ready;

    // Words already owned downstream of ra: stored, in flight, minus the one leaving now.
    assign level = {1'b0, occ} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, pop};
    assign issue = (r_state == R_BURST) && (level < (OW+1)'(SKID));

    always_comb begin
        w_next        = w_state;
        r_next        = r_state;
        ram.din_valid = row_acc;
        ram.be        = row_acc ? 8'hFF : 8'h00;
        ram.di        = row_acc ? row_data : '0;
        ram.wa        = wcnt;
        ram.ra        = rcnt;
        ram.rnw       = rnw_q;
        case (w_state)
            W_FILL: if (row_acc && wcnt == AW'(NROW - 1)) w_next = W_FULL;
            W_FULL: if (swap) w_next = W_FILL;
        endcase
        case (r_state)
            R_IDLE:  if (swap) r_next = R_BURST;
            R_BURST: if (issue && rcnt == AW'(NROW - 1)) r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_FILL;
            r_state  <= R_IDLE;
            wcnt     <= '0;
            rcnt     <= '0;
            rnw_q    <= 1'b1;
            inflight <= 1'b0;
            infl_idx <= '0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            inflight <= issue;
            if (row_acc) begin
                wcnt <= wcnt + 1'b1;
            end
            if (swap) begin
                rnw_q <= !rnw_q;
                rcnt  <= '0;
            end else if (issue) begin
                rcnt <= rcnt + 1'b1;
            end
            if (issue) begin
                infl_idx <= rcnt;
            end
        end
    end

    assign push_word = {infl_idx == AW'(NROW - 1), infl_idx, ram.do_in};

    skid_fifo #(
        .W     (DW + AW + 1),
        .DEPTH (SKID),
        .CW    (OW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight),
        .in_data   (push_word),
        .out_valid (col_valid),
        .out_data  (head),
        .out_ready (col_ready),
        .occ       (occ)
    );

    assign {col_last, col_idx, col_data} = head;
endmodule

// File: tb/tb_tbuf_ctrl.sv
// Directed bench for tbuf_ctrl with a behavioural dualram and a column scoreboard.
module tb_tbuf_ctrl;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        row_valid = 1'b0;
    logic [63:0] row_data = '0;
    logic        row_ready;
    logic        col_valid;
    logic [63:0] col_data;
    logic [2:0]  col_idx;
    logic        col_last;
    logic        col_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int base  = 0;
    int ncyc  = 0;

    tbuf_if #(.DW(64), .AW(3)) bus ();

    tbuf_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_ready (row_ready),
        .ram       (bus),
        .col_valid (col_valid),
        .col_data  (col_data),
        .col_idx   (col_idx),
        .col_last  (col_last),
        .col_ready (col_ready)
    );

    always #5 clk = ~clk;

    // dualram: rnw=1 writes ram1 and reads ram2; registered read port.
    logic [63:0] bank1 [8];
    logic [63:0] bank2 [8];
    always @(posedge clk) begin
        if (bus.din_valid) begin
            if (bus.rnw) bank1[bus.wa] <= bus.di;
            else         bank2[bus.wa] <= bus.di;
        end
        bus.do_in <= bus.rnw ? bank2[bus.ra] : bank1[bus.ra];
    end

    logic       tr_rnw [256];
    logic       tr_rr  [256];
    logic       tr_rv  [256];
    logic       tr_cv  [256];
    logic [2:0] tr_ra  [256];
    logic [2:0] tr_ci  [256];

    typedef struct {
        logic       rv;
        logic       cr;
        logic       rr;
        logic       dv;
        logic [2:0] wa;
        logic       rnw;
        logic [2:0] ra;
        logic       cv;
        logic [2:0] ci;
        logic       cl;
    } vec_t;

    vec_t tv [19];

    function automatic logic [63:0] word(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {8{b}};
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name,
              256'({row_ready, bus.din_valid, bus.be, bus.di, bus.wa, bus.ra, bus.rnw,
                    col_valid, col_idx, col_last, col_data}),
              256'({1'b0, 1'b0, 8'h00, 64'h0, 3'd0, 3'd0, 1'b1,
                    1'b0, 3'd0, 1'b0, 64'h0}));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        col_ready = 1'b1;
        #1;
        check_reset_vals("reset_vals");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams nrows rows from base, drops col_ready for hold_n cycles from hold_s,
    // checks every column against the accepted-row order and records a trace.
    task automatic run(input int nrows, input int hold_s, input int hold_n, input int max_cyc);
        int          sent = 0;
        int          rcvd = 0;
        logic [63:0] exp_q [$];
        logic [2:0]  eidx;
        logic [63:0] edata;
        for (int c = 0; c < max_cyc && rcvd < nrows; c++) begin
            row_valid = (sent < nrows);
            row_data  = row_valid ? word(base + sent) : '0;
            col_ready = !(c >= hold_s && c < hold_s + hold_n);
            #1;
            tr_rnw[c] = bus.rnw;
            tr_rr[c]  = row_ready;
            tr_rv[c]  = row_valid;
            tr_ra[c]  = bus.ra;
            tr_cv[c]  = col_valid;
            tr_ci[c]  = col_idx;
            if (col_valid && col_ready) begin
                eidx  = 3'(rcvd % 8);
                edata = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                check($sformatf("col[%0d]", rcvd),
                      256'({col_last, col_idx, col_data}),
                      256'({eidx == 3'd7, eidx, edata}));
                rcvd++;
            end
            if (row_valid && row_ready) begin
                exp_q.push_back(word(base + sent));
                sent++;
            end
            ncyc = c + 1;
            @(negedge clk);
        end
        row_valid = 1'b0;
        col_ready = 1'b1;
        check("cols_received", 256'(rcvd), 256'(nrows));
    endtask

    initial begin
        int lows;
        int flips;
        logic [63:0] dexp;

        tv[0]  = '{H, H, H, H, 3'd0, H, 3'd0, L, 3'd0, L};
        tv[1]  = '{H, H, H, H, 3'd1, H, 3'd0, L, 3'd0, L};
        tv[2]  = '{H, H, H, H, 3'd2, H, 3'd0, L, 3'd0, L};
        tv[3]  = '{H, H, H, H, 3'd3, H, 3'd0, L, 3'd0, L};
        tv[4]  = '{H, H, H, H, 3'd4, H, 3'd0, L, 3'd0, L};
        tv[5]  = '{H, H, H, H, 3'd5, H, 3'd0, L, 3'd0, L};
        tv[6]  = '{H, H, H, H, 3'd6, H, 3'd0, L, 3'd0, L};
        tv[7]  = '{H, H, H, H, 3'd7, H, 3'd0, L, 3'd0, L};
        tv[8]  = '{L, H, L, L, 3'd0, H, 3'd0, L, 3'd0, L};
        tv[9]  = '{L, H, H, L, 3'd0, L, 3'd0, L, 3'd0, L};
        tv[10] = '{L, H, H, L, 3'd0, L, 3'd1, H, 3'd0, L};
        tv[11] = '{L, H, H, L, 3'd0, L, 3'd2, H, 3'd1, L};
        tv[12] = '{L, H, H, L, 3'd0, L, 3'd3, H, 3'd2, L};
        tv[13] = '{L, H, H, L, 3'd0, L, 3'd4, H, 3'd3, L};
        tv[14] = '{L, H, H, L, 3'd0, L, 3'd5, H, 3'd4, L};
        tv[15] = '{L, H, H, L, 3'd0, L, 3'd6, H, 3'd5, L};
        tv[16] = '{L, H, H, L, 3'd0, L, 3'd7, H, 3'd6, L};
        tv[17] = '{L, H, H, L, 3'd0, L, 3'd0, H, 3'd7, H};
        tv[18] = '{L, H, H, L, 3'd0, L, 3'd0, L, 3'd0, L};

        @(negedge clk);

        // First block, cycle-exact
        do_reset();
        for (int i = 0; i < 19; i++) begin
            row_valid = tv[i].rv;
            row_data  = tv[i].rv ? word(i + 1) : '0;
            col_ready = tv[i].cr;
            #1;
            dexp = tv[i].cv ? word(int'(tv[i].ci) + 1) : 64'h0;
            check($sformatf("vec[%0d]", i),
                  256'({row_ready, bus.din_valid, bus.be, bus.di, bus.wa, bus.rnw, bus.ra,
                        col_valid, col_idx, col_last, col_data}),
                  256'({tv[i].rr, tv[i].dv, tv[i].dv ? 8'hFF : 8'h00,
                        tv[i].dv ? word(i + 1) : 64'h0, tv[i].wa, tv[i].rnw, tv[i].ra,
                        tv[i].cv, tv[i].ci, tv[i].cl, dexp}));
            @(negedge clk);
        end

        // Three blocks streamed back to back
        do_reset();
        base = 32;
        run(24, 999, 0, 100);
        lows = 0;
        flips = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (tr_rv[c] && !tr_rr[c]) lows++;
            if (c > 0 && tr_rnw[c] != tr_rnw[c-1]) flips++;
        end
        check("stream_rr_low", 256'(lows), 256'(2));
        check("stream_rnw_flips", 256'(flips), 256'(3));
        check("coincident_swap",
              256'({tr_ra[16], tr_rr[16], tr_ra[17], tr_rr[17], tr_rnw[17], tr_rnw[18], tr_rr[18]}),
              256'({3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}));
        check("stream_third_swap", 256'({tr_rnw[26], tr_rnw[27]}), 256'({1'b1, 1'b0}));

        // Five-cycle col_ready stall mid-burst
        do_reset();
        base = 80;
        run(8, 12, 5, 60);
        check("stall_ra", 256'({tr_ra[12], tr_ra[13], tr_ra[16], tr_ra[17]}),
              256'({3'd3, 3'd4, 3'd4, 3'd4}));
        check("stall_head", 256'({tr_cv[12], tr_ci[12], tr_cv[16], tr_ci[16]}),
              256'({1'b1, 3'd2, 1'b1, 3'd2}));

        // Writer fills block 2 while the reader is held off
        do_reset();
        base = 128;
        run(16, 9, 20, 120);
        lows = 0;
        for (int c = 17; c <= 35; c++) begin
            if (!tr_rr[c]) lows++;
        end
        check("w_full_hold", 256'(lows), 256'(19));
        check("w_fill_block2", 256'({tr_rr[9], tr_rr[16]}), 256'({1'b1, 1'b1}));
        check("reader_frozen", 256'({tr_ra[10], tr_ra[11], tr_ra[28]}),
              256'({3'd1, 3'd2, 3'd2}));
        check("late_swap", 256'({tr_ra[34], tr_ra[35], tr_rnw[35], tr_rr[35], tr_rnw[36], tr_rr[36]}),
              256'({3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}));

        // Asynchronous reset after four rows
        do_reset();
        base = 48;
        for (int k = 0; k < 4; k++) begin
            row_valid = 1'b1;
            row_data  = word(base + k);
            @(negedge clk);
        end
        row_valid = 1'b1;
        row_data  = word(base + 4);
        #1;
        check("pre_reset", 256'({bus.din_valid, bus.wa, bus.rnw}), 256'({1'b1, 3'd4, 1'b1}));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = 96;
        run(8, 999, 0, 40);
        check("post_reset_block0", 256'({tr_rnw[0], tr_rnw[8], tr_rnw[9]}),
              256'({1'b1, 1'b1, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
